// File: rtl/frame_buf_pkg.sv
// Shared types and default geometry for the frame buffer arbiter.
package frame_buf_pkg;

    // Arbiter ownership state; encoding is visible on o_STATE.
    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_HOST_WRITE = 2'd1,
        ST_PROC_BUSY  = 2'd2,
        ST_HOST_READ  = 2'd3
    } fb_state_e;

    localparam int DEF_H_PIX       = 320;
    localparam int DEF_V_PIX       = 240;
    localparam int DEF_ADDR_W      = 17;
    localparam int DEF_TIMEOUT_CYC = 1048576;
    localparam int DEF_CNT_W       = 16;

endpackage

// File: rtl/frame_pix_counter.sv
// Counts accepted pixel reads within a frame and flags the last one.
module frame_pix_counter #(
    parameter int FRAME_PIX = 8,
    parameter int ADDR_W    = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic tc
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(FRAME_PIX - 1);

    logic [ADDR_W-1:0] count;

    // Terminal count is combinational so the owner can react on the same edge.
    assign tc = inc && (count == LAST);

    // Pixel counter: clear wins, wraps to zero on the last pixel of a frame.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr || tc) begin
            count <= '0;
        end else if (inc) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/frame_buf_arbiter.sv
// Arbitrates color/gray frame RAM ports between a host and a processor.
module frame_buf_arbiter
    import frame_buf_pkg::*;
#(
    parameter int H_PIX       = DEF_H_PIX,
    parameter int V_PIX       = DEF_V_PIX,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic              i_CLK,
    input  logic              i_RSTn,
    input  logic              i_START,
    input  logic              i_ABORT,
    input  logic              i_CLR_ERR,
    input  logic              i_HOST_WRITE,
    input  logic              i_HOST_READ,
    input  logic [ADDR_W-1:0] i_HOST_ADDR,
    input  logic              i_HOST_GRAY_READ,
    input  logic [ADDR_W-1:0] i_HOST_GRAY_ADDR,
    input  logic              i_PROC_READ,
    input  logic [ADDR_W-1:0] i_PROC_RD_ADDR,
    input  logic [ADDR_W-1:0] i_PROC_WR_ADDR,
    input  logic              i_DONE_WRITE_COLOR,
    input  logic              i_DONE_WRITE_GRAY,
    output logic              o_COLOR_WRITE,
    output logic              o_COLOR_READ,
    output logic [ADDR_W-1:0] o_COLOR_ADDR,
    output logic              o_GRAY_READ,
    output logic [ADDR_W-1:0] o_GRAY_ADDR,
    output logic [1:0]        o_STATE,
    output logic              o_BUSY,
    output logic              o_FRAME_DONE,
    output logic [CNT_W-1:0]  o_FRAME_CNT,
    output logic              o_TIMEOUT
);

    localparam int FRAME_PIX = H_PIX * V_PIX;
    // One spare bit so the counter never wraps while leaving PROC_BUSY.
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    fb_state_e       state, state_nxt;
    logic [TO_W-1:0] to_cnt;
    logic            read_inc, read_tc, timeout_set;

    // Only gray reads while the host owns the gray RAM advance the frame.
    assign read_inc = (state == ST_HOST_READ) && i_HOST_GRAY_READ && !i_ABORT;

    frame_pix_counter #(
        .FRAME_PIX (FRAME_PIX),
        .ADDR_W    (ADDR_W)
    ) u_read_cnt (
        .clk   (i_CLK),
        .rst_n (i_RSTn),
        .clr   (i_ABORT),
        .inc   (read_inc),
        .tc    (read_tc)
    );

    // Next-state selection; abort overrides everything, timeout beats a late done.
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_nxt   = state;
        timeout_set = 1'b0;
        if (i_ABORT) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:       if (i_START) state_nxt = ST_HOST_WRITE;
                ST_HOST_WRITE: if (i_DONE_WRITE_COLOR) state_nxt = ST_PROC_BUSY;
                ST_PROC_BUSY: begin
                    if (to_cnt == TO_LAST) begin
                        timeout_set = 1'b1;
                        state_nxt   = ST_IDLE;
                    end else if (i_DONE_WRITE_GRAY) begin
                        state_nxt = ST_HOST_READ;
                    end
                end
                ST_HOST_READ: begin
                    if (read_tc) state_nxt = i_START ? ST_HOST_WRITE : ST_IDLE;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge i_CLK or negedge i_RSTn) begin
        if (!i_RSTn) state <= ST_IDLE;
        else         state <= state_nxt;
    end

    // Cycles spent in PROC_BUSY; held at zero elsewhere so entry starts at zero.
    always_ff @(posedge i_CLK or negedge i_RSTn) begin
        if (!i_RSTn) begin
            to_cnt <= '0;
        end else if (state != ST_PROC_BUSY || i_ABORT) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    // Frame completion pulse and frame counter (abort already masks read_tc).
    always_ff @(posedge i_CLK or negedge i_RSTn) begin
        if (!i_RSTn) begin
            o_FRAME_DONE <= 1'b0;
            o_FRAME_CNT  <= '0;
        end else begin
            o_FRAME_DONE <= read_tc;
            if (read_tc) o_FRAME_CNT <= o_FRAME_CNT + 1'b1;
        end
    end

    // Sticky timeout flag; a set in the same cycle as a clear wins.
    always_ff @(posedge i_CLK or negedge i_RSTn) begin
        if (!i_RSTn)        o_TIMEOUT <= 1'b0;
        else if (timeout_set) o_TIMEOUT <= 1'b1;
        else if (i_CLR_ERR)   o_TIMEOUT <= 1'b0;
    end

    // RAM port steering: the processor owns both ports only in PROC_BUSY.
    always_comb begin
        o_COLOR_WRITE = 1'b0;
        o_GRAY_READ   = 1'b0;
        o_COLOR_READ  = i_HOST_READ;
        o_COLOR_ADDR  = i_HOST_ADDR;
        o_GRAY_ADDR   = i_HOST_GRAY_ADDR;
        case (state)
            ST_HOST_WRITE: o_COLOR_WRITE = i_HOST_WRITE;
            ST_HOST_READ:  o_GRAY_READ   = i_HOST_GRAY_READ;
            ST_PROC_BUSY: begin
                o_COLOR_READ = i_PROC_READ;
                o_COLOR_ADDR = i_PROC_RD_ADDR;
                o_GRAY_ADDR  = i_PROC_WR_ADDR;
            end
            default: ;
        endcase
    end

    assign o_STATE = state;
    assign o_BUSY  = (state != ST_IDLE);

endmodule

// File: tb/tb_frame_buf_arbiter.sv
// Randomized and directed bench for frame_buf_arbiter against a cycle model.
module tb_frame_buf_arbiter;

    localparam int H_PIX       = 4;
    localparam int V_PIX       = 2;
    localparam int FRAME_PIX   = H_PIX * V_PIX;
    localparam int ADDR_W      = 17;
    localparam int TIMEOUT_CYC = 16;
    localparam int CNT_W       = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              start, abort, clr_err;
    logic              host_write, host_read, host_gray_read;
    logic [ADDR_W-1:0] host_addr, host_gray_addr;
    logic              proc_read;
    logic [ADDR_W-1:0] proc_rd_addr, proc_wr_addr;
    logic              done_color, done_gray;

    logic              color_write, color_read, gray_read;
    logic [ADDR_W-1:0] color_addr, gray_addr;
    logic [1:0]        state;
    logic              busy, frame_done, timeout;
    logic [CNT_W-1:0]  frame_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: phase number as the spec numbers it, plain counters.
    int m_state, m_reads, m_busy_cycles, m_cnt;
    bit m_done, m_to;

    frame_buf_arbiter #(
        .H_PIX (H_PIX), .V_PIX (V_PIX), .ADDR_W (ADDR_W),
        .TIMEOUT_CYC (TIMEOUT_CYC), .CNT_W (CNT_W)
    ) dut (
        .i_CLK (clk), .i_RSTn (rst_n), .i_START (start), .i_ABORT (abort),
        .i_CLR_ERR (clr_err), .i_HOST_WRITE (host_write), .i_HOST_READ (host_read),
        .i_HOST_ADDR (host_addr), .i_HOST_GRAY_READ (host_gray_read),
        .i_HOST_GRAY_ADDR (host_gray_addr), .i_PROC_READ (proc_read),
        .i_PROC_RD_ADDR (proc_rd_addr), .i_PROC_WR_ADDR (proc_wr_addr),
        .i_DONE_WRITE_COLOR (done_color), .i_DONE_WRITE_GRAY (done_gray),
        .o_COLOR_WRITE (color_write), .o_COLOR_READ (color_read),
        .o_COLOR_ADDR (color_addr), .o_GRAY_READ (gray_read), .o_GRAY_ADDR (gray_addr),
        .o_STATE (state), .o_BUSY (busy), .o_FRAME_DONE (frame_done),
        .o_FRAME_CNT (frame_cnt), .o_TIMEOUT (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        start = 0; abort = 0; clr_err = 0; host_write = 0; host_read = 0;
        host_gray_read = 0; proc_read = 0; done_color = 0; done_gray = 0;
        host_addr = '0; host_gray_addr = '0; proc_rd_addr = '0; proc_wr_addr = '0;
    endtask

    // Advance the model by one clock using the inputs presented this cycle.
    task automatic model_step();
        bit to_set;
        to_set = 0;
        m_done = 0;
        if (abort) begin
            m_state = 0; m_reads = 0; m_busy_cycles = 0;
        end else begin
            case (m_state)
                0: if (start) m_state = 1;
                1: if (done_color) begin m_state = 2; m_busy_cycles = 0; end
                2: begin
                    m_busy_cycles++;
                    if (m_busy_cycles == TIMEOUT_CYC) begin
                        to_set = 1; m_state = 0;
                    end else if (done_gray) begin
                        m_state = 3;
                    end
                end
                default: if (host_gray_read) begin
                    m_reads++;
                    if (m_reads == FRAME_PIX) begin
                        m_reads = 0; m_done = 1;
                        m_cnt = (m_cnt + 1) % (1 << CNT_W);
                        m_state = start ? 1 : 0;
                    end
                end
            endcase
        end
        if (to_set)       m_to = 1;
        else if (clr_err) m_to = 0;
    endtask

    // One clock: check port steering mid-cycle, then registered outputs after the edge.
    task automatic tick();
        #2;
        check("color_write", color_write, (m_state == 1) && host_write);
        check("gray_read", gray_read, (m_state == 3) && host_gray_read);
        check("color_read", color_read, (m_state == 2) ? proc_read : host_read);
        check("color_addr", color_addr, (m_state == 2) ? proc_rd_addr : host_addr);
        check("gray_addr", gray_addr, (m_state == 2) ? proc_wr_addr : host_gray_addr);
        @(posedge clk);
        model_step();
        #1;
        check("state", state, m_state);
        check("busy", busy, m_state != 0);
        check("frame_done", frame_done, m_done);
        check("frame_cnt", frame_cnt, m_cnt);
        check("timeout", timeout, m_to);
    endtask

    // Assert reset between edges and confirm outputs clear before the next edge.
    task automatic do_reset();
        idle_inputs();
        #2;
        rst_n = 0;
        m_state = 0; m_reads = 0; m_busy_cycles = 0; m_cnt = 0; m_done = 0; m_to = 0;
        #1;
        check("rst_state", state, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_frame_cnt", frame_cnt, 0);
        check("rst_timeout", timeout, 0);
        @(posedge clk);
        #2;
        rst_n = 1;
    endtask

    task automatic run_to_read();
        start = 1;      tick(); start = 0;
        done_color = 1; tick(); done_color = 0;
        done_gray = 1;  tick(); done_gray = 0;
    endtask

    task automatic do_reads(input int n);
        host_gray_read = 1;
        repeat (n) tick();
        host_gray_read = 0;
    endtask

    initial begin
        idle_inputs();
        do_reset();

        // Single frame with START released.
        start = 1; tick(); check("n_s1", state, 1); start = 0;
        done_color = 1; tick(); check("n_s2", state, 2); done_color = 0;
        done_gray = 1;  tick(); check("n_s3", state, 3); done_gray = 0;
        host_gray_read = 1;
        repeat (7) tick();
        check("n_pre_done", frame_done, 0);
        tick();
        check("n_s0", state, 0);
        check("n_done", frame_done, 1);
        check("n_cnt", frame_cnt, 1);
        host_gray_read = 0;
        tick();
        check("n_done_pulse", frame_done, 0);

        // Continuous frames with START held.
        do_reset();
        run_to_read();
        start = 1;
        do_reads(FRAME_PIX);
        check("c_s1", state, 1);
        check("c_cnt1", frame_cnt, 1);
        start = 0;
        done_color = 1; tick(); done_color = 0;
        done_gray = 1;  tick(); done_gray = 0;
        do_reads(FRAME_PIX);
        check("c_cnt2", frame_cnt, 2);
        check("c_s0", state, 0);

        // Processor owns the ports in PROC_BUSY; host write is masked.
        do_reset();
        start = 1; tick(); start = 0;
        done_color = 1; tick(); done_color = 0;
        check("m_s2", state, 2);
        proc_rd_addr = 5; proc_wr_addr = 6; host_write = 1; host_addr = 9; host_gray_addr = 11;
        #1;
        check("m_color_addr", color_addr, 5);
        check("m_gray_addr", gray_addr, 6);
        check("m_color_write", color_write, 0);
        tick();
        idle_inputs();

        // Timeout after TIMEOUT_CYC cycles in PROC_BUSY; set beats a simultaneous clear.
        do_reset();
        start = 1; tick(); start = 0;
        done_color = 1; tick(); done_color = 0;
        repeat (TIMEOUT_CYC - 1) tick();
        check("t_still_busy", state, 2);
        check("t_not_yet", timeout, 0);
        clr_err = 1; tick();
        check("t_idle", state, 0);
        check("t_set", timeout, 1);
        tick();
        check("t_cleared", timeout, 0);
        clr_err = 0;

        // Abort mid-read discards progress; next frame needs all reads.
        do_reset();
        run_to_read();
        do_reads(3);
        abort = 1; tick(); abort = 0;
        check("a_idle", state, 0);
        check("a_no_done", frame_done, 0);
        check("a_cnt", frame_cnt, 0);
        run_to_read();
        do_reads(FRAME_PIX - 1);
        check("a_s3", state, 3);
        check("a_pre_done", frame_done, 0);
        do_reads(1);
        check("a_done", frame_done, 1);
        check("a_cnt1", frame_cnt, 1);

        // Reset mid-PROC_BUSY with a nonzero frame count and timeout pending.
        do_reset();
        start = 1; tick(); start = 0;
        done_color = 1; tick(); done_color = 0;
        repeat (TIMEOUT_CYC) tick();
        run_to_read();
        do_reads(FRAME_PIX);
        start = 1; tick(); start = 0;
        done_color = 1; tick(); done_color = 0;
        check("r_pre_busy", state, 2);
        check("r_pre_cnt", frame_cnt, 1);
        check("r_pre_to", timeout, 1);
        do_reset();
        run_to_read();
        do_reads(FRAME_PIX - 1);
        check("r_partial", frame_done, 0);
        do_reads(1);
        check("r_full", frame_done, 1);

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            start          = ($urandom_range(0, 3) != 0);
            abort          = ($urandom_range(0, 39) == 0);
            clr_err        = ($urandom_range(0, 7) == 0);
            host_write     = $urandom_range(0, 1);
            host_read      = $urandom_range(0, 1);
            host_gray_read = ($urandom_range(0, 3) != 0);
            proc_read      = $urandom_range(0, 1);
            done_color     = ($urandom_range(0, 3) == 0);
            done_gray      = ($urandom_range(0, 9) == 0);
            host_addr      = ADDR_W'($urandom);
            host_gray_addr = ADDR_W'($urandom);
            proc_rd_addr   = ADDR_W'($urandom);
            proc_wr_addr   = ADDR_W'($urandom);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/frame_buf_arbiter.md
FRAME_BUF_ARBITER -- requirements
Module: frame_buf_arbiter

Interface
REQ-001 Parameter H_PIX, 320, pixels per line.
REQ-002 Parameter V_PIX, 240, lines per frame; FRAME_PIX = H_PIX*V_PIX.
REQ-003 Parameter ADDR_W, 17, pixel address width; SHALL satisfy 2^ADDR_W >= FRAME_PIX.
REQ-004 Parameter TIMEOUT_CYC, 1048576, maximum cycles allowed in PROC_BUSY.
REQ-005 Parameter CNT_W, 16, frame counter width.
REQ-006 i_CLK  in  1  single clock; all logic rising-edge.
REQ-007 i_RSTn  in  1  reset, asynchronous assert, active-low.
REQ-008 i_START  in  1  level request to begin or continue frames.
REQ-009 i_ABORT  in  1  synchronous abort to IDLE.
REQ-010 i_CLR_ERR  in  1  clears o_TIMEOUT.
REQ-011 i_HOST_WRITE, i_HOST_READ  in  1 each  host color-RAM strobes.
REQ-012 i_HOST_ADDR  in  ADDR_W  host color-RAM address.
REQ-013 i_HOST_GRAY_READ  in  1; i_HOST_GRAY_ADDR  in  ADDR_W  host gray-RAM read port.
REQ-014 i_PROC_READ  in  1; i_PROC_RD_ADDR, i_PROC_WR_ADDR  in  ADDR_W  processor ports.
REQ-015 i_DONE_WRITE_COLOR, i_DONE_WRITE_GRAY  in  1  single-cycle completion pulses from RAM controllers.
REQ-016 o_COLOR_WRITE, o_COLOR_READ  out  1; o_COLOR_ADDR  out  ADDR_W  muxed color-RAM port.
REQ-017 o_GRAY_READ  out  1; o_GRAY_ADDR  out  ADDR_W  muxed gray-RAM port.
REQ-018 o_STATE  out  2  encoded state; o_BUSY  out  1  state != IDLE.
REQ-019 o_FRAME_DONE  out  1  one-cycle pulse; o_FRAME_CNT  out  CNT_W; o_TIMEOUT  out  1 sticky.

Function
REQ-020 States SHALL be IDLE=0, HOST_WRITE=1, PROC_BUSY=2, HOST_READ=3, registered.
REQ-021 IDLE->HOST_WRITE when i_START=1.
REQ-022 HOST_WRITE->PROC_BUSY on i_DONE_WRITE_COLOR.
REQ-023 PROC_BUSY->HOST_READ on i_DONE_WRITE_GRAY.
REQ-024 HOST_READ: gray-read counter increments per cycle with i_HOST_GRAY_READ=1; on the read with count FRAME_PIX-1, counter wraps to 0, o_FRAME_DONE pulses next cycle, o_FRAME_CNT increments (wraps at 2^CNT_W), state -> HOST_WRITE if i_START=1 else IDLE.
REQ-025 Mux (combinational from state): HOST_WRITE/HOST_READ/IDLE -> color port from host, gray address from i_HOST_GRAY_ADDR; PROC_BUSY -> o_COLOR_READ=i_PROC_READ, o_COLOR_ADDR=i_PROC_RD_ADDR, o_GRAY_ADDR=i_PROC_WR_ADDR.
REQ-026 o_COLOR_WRITE = i_HOST_WRITE only in HOST_WRITE, else 0.
REQ-027 o_GRAY_READ = i_HOST_GRAY_READ only in HOST_READ, else 0; gray reads elsewhere not counted.
REQ-028 Completion pulses arriving in any non-matching state SHALL be ignored.
REQ-029 Timeout counter clears on PROC_BUSY entry; reaching TIMEOUT_CYC-1 in PROC_BUSY sets o_TIMEOUT and forces IDLE.
REQ-030 o_TIMEOUT holds until i_CLR_ERR=1 or reset; a simultaneous set and clear SHALL leave it set.
REQ-031 i_ABORT=1 in any state forces IDLE next cycle, clears read and timeout counters, suppresses o_FRAME_DONE; o_FRAME_CNT unchanged; ABORT has priority over every other transition.

Reset
REQ-032 i_RSTn=0 SHALL immediately force state IDLE, all counters 0, o_FRAME_DONE=0, o_TIMEOUT=0, o_FRAME_CNT=0.
REQ-033 Reset mid-frame SHALL discard progress; first post-reset frame restarts from HOST_WRITE with read count 0.

Structure
REQ-034 State enum, its 2-bit encoding and default frame constants SHALL live in shared package frame_buf_pkg.
REQ-035 Read counter with terminal-count pulse SHALL be sub-module frame_pix_counter (parameters FRAME_PIX, ADDR_W).

Verification (H_PIX=4, V_PIX=2, TIMEOUT_CYC=16)
REQ-036 Normal: START=1, DONE_WRITE_COLOR, DONE_WRITE_GRAY, 8 gray reads with START=0 -> states 1,2,3,0; FRAME_DONE one pulse; FRAME_CNT=1.
REQ-037 Continuous: START held through 8th read -> state 3->1, FRAME_CNT=1, second frame reaches FRAME_CNT=2.
REQ-038 Mux: in PROC_BUSY drive PROC_RD_ADDR=5, PROC_WR_ADDR=6, HOST_WRITE=1 -> COLOR_ADDR=5, GRAY_ADDR=6, COLOR_WRITE=0.
REQ-039 Timeout: no DONE_WRITE_GRAY for 16 cycles in PROC_BUSY -> TIMEOUT=1, IDLE; CLR_ERR -> TIMEOUT=0.
REQ-040 Abort: ABORT after 3 gray reads -> IDLE, no FRAME_DONE; next frame needs 8 full reads.
REQ-041 Reset: assert i_RSTn=0 mid-PROC_BUSY between clock edges -> state 0 and outputs cleared before next edge.
